// File: rtl/md5_pad.sv
// MD5 message pre-processor: buffers message bytes, appends 0x80 / zero fill / 64-bit
// bit length, and streams each 512-bit block to md5sum as 16 little-endian words.
module md5_pad #(
    parameter int LEN_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic        din_valid,
    input  logic        din_last,
    input  logic        empty_msg,
    output logic        din_ready,
    input  logic        rdy,
    output logic [31:0] msg,
    output logic        write_en,
    output logic        blk_last,
    output logic        msg_done
);

    localparam logic [2:0] ST_ACCEPT = 3'd0;
    localparam logic [2:0] ST_PAD    = 3'd1;
    localparam logic [2:0] ST_LEN    = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_EMIT   = 3'd4;

    logic [2:0]       state;
    logic [31:0]      buf_mem [16];
    logic [5:0]       idx;
    logic [LEN_W-1:0] count;
    logic [3:0]       emit_cnt;
    logic             marker_done;
    logic             blk_is_last;
    logic             more_pad;
    logic             live;
    logic             done_q;
    logic [63:0]      bit_len;
    logic             take;

    assign bit_len   = {{(61-LEN_W){1'b0}}, count, 3'b000};
    assign din_ready = live && (state == ST_ACCEPT);
    assign take      = din_valid && din_ready;
    assign write_en  = (state == ST_EMIT);
    assign msg       = write_en ? buf_mem[emit_cnt] : '0;
    assign blk_last  = write_en && blk_is_last;
    assign msg_done  = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ACCEPT;
            idx         <= '0;
            count       <= '0;
            emit_cnt    <= '0;
            marker_done <= 1'b0;
            blk_is_last <= 1'b0;
            more_pad    <= 1'b0;
            live        <= 1'b0;
            done_q      <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            live   <= 1'b1;
            done_q <= 1'b0;
            case (state)
                ST_ACCEPT: begin
                    if (take) begin
                        buf_mem[idx[5:2]][{idx[1:0], 3'b000} +: 8] <= din;
                        idx   <= idx + 6'd1;
                        count <= count + LEN_W'(1);
                        if (idx == 6'd63) begin
                            // Full data block; a din_last here defers all padding to a new block.
                            blk_is_last <= 1'b0;
                            more_pad    <= din_last;
                            state       <= ST_WAIT;
                        end else if (din_last) begin
                            state <= ST_PAD;
                        end
                    end else if (live && empty_msg) begin
                        count <= '0;
                        state <= ST_PAD;
                    end
                end
                ST_PAD: begin
                    if (marker_done && idx == 6'd56) begin
                        state <= ST_LEN;
                    end else begin
                        buf_mem[idx[5:2]][{idx[1:0], 3'b000} +: 8] <= marker_done ? 8'h00 : 8'h80;
                        marker_done <= 1'b1;
                        idx         <= idx + 6'd1;
                        if (idx == 6'd63) begin
                            blk_is_last <= 1'b0;
                            more_pad    <= 1'b1;
                            state       <= ST_WAIT;
                        end
                    end
                end
                ST_LEN: begin
                    buf_mem[14] <= bit_len[31:0];
                    buf_mem[15] <= bit_len[63:32];
                    blk_is_last <= 1'b1;
                    more_pad    <= 1'b0;
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (rdy) begin
                        emit_cnt <= '0;
                        state    <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    emit_cnt <= emit_cnt + 4'd1;
                    if (emit_cnt == 4'd15) begin
                        if (more_pad) begin
                            more_pad <= 1'b0;
                            state    <= ST_PAD;
                        end else if (!blk_is_last) begin
                            state <= ST_ACCEPT;
                        end else begin
                            done_q      <= 1'b1;
                            count       <= '0;
                            idx         <= '0;
                            marker_done <= 1'b0;
                            blk_is_last <= 1'b0;
                            state       <= ST_ACCEPT;
                            for (int unsigned i = 0; i < 16; i++) begin
                                buf_mem[i] <= '0;
                            end
                        end
                    end
                end
                default: state <= ST_ACCEPT;
            endcase
        end
    end

endmodule
